// File: rtl/rob_defs.sv
`default_nettype none
// ============================================================================
// Module      : rob_defs (package)
// Description : Shared ROB types and writeback-arbiter sizing constants.
// Revision    : 1.0 - initial release
// ============================================================================
package rob_defs;

   localparam int RB_NUM_ENTRIES   = 48;
   localparam int RB_ROBID_W       = 6;
   localparam int RB_NUM_WB_PORTS  = 3;
   localparam int RB_WB_FIFO_DEPTH = 2;
   localparam int RB_WB_IDX_W      = (RB_NUM_WB_PORTS > 1) ? $clog2(RB_NUM_WB_PORTS) : 1;

   typedef logic [RB_WB_IDX_W-1:0] t_wb_req_idx;

   typedef struct packed {
      logic [RB_ROBID_W-1:0] robid;
      logic [31:0]           data;
   } t_rob_result;

   // Reduce an integer onto the requester index range.
   function automatic t_wb_req_idx wb_idx_wrap(input int v, input int n);
      return t_wb_req_idx'(v % n);
   endfunction

endpackage
`default_nettype wire

// File: rtl/rob_wb_arb_fifo.sv
`default_nettype none
// ============================================================================
// Module      : wb_skid_fifo
// Description : Per-requester skid FIFO with synchronous flush.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_skid_fifo #(
   parameter int  DEPTH = 2,
   parameter type T     = logic [7:0],
   localparam int c_cnt_w = $clog2(DEPTH + 1)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               flush,
   input  logic               push,
   input  T                   push_data,
   input  logic               pop,
   output T                   head,
   output logic [c_cnt_w-1:0] count
);

   localparam int                 c_ptr_w    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [c_cnt_w-1:0] c_depth    = c_cnt_w'(DEPTH);
   localparam logic [c_ptr_w-1:0] c_last_ptr = c_ptr_w'(DEPTH - 1);

   T                   r_mem [DEPTH];
   logic [c_ptr_w-1:0] r_wr_ptr;
   logic [c_ptr_w-1:0] r_rd_ptr;
   logic [c_cnt_w-1:0] r_count;
   logic               w_push_ok;
   logic               w_pop_ok;

   // Pushes into a full FIFO are dropped; upstream must honour ready.
   assign w_push_ok = push && (r_count < c_depth);
   assign w_pop_ok  = pop && (r_count != '0);

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push_ok)
            r_wr_ptr <= (r_wr_ptr == c_last_ptr) ? '0 : r_wr_ptr + 1'b1;
         if (w_pop_ok)
            r_rd_ptr <= (r_rd_ptr == c_last_ptr) ? '0 : r_rd_ptr + 1'b1;
         if (w_push_ok && !w_pop_ok)
            r_count <= r_count + 1'b1;
         else if (!w_push_ok && w_pop_ok)
            r_count <= r_count - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_push_ok && !flush)
         r_mem[r_wr_ptr] <= push_data;
   end

   assign head  = r_mem[r_rd_ptr];
   assign count = r_count;

`ifdef ASSERT
   always_ff @(posedge clk) begin
      if (!reset)
         assert (!(push && (r_count == c_depth)));
   end
`endif

endmodule
`default_nettype wire

// File: rtl/rob_wb_arb.sv
`default_nettype none
// ============================================================================
// Module      : rob_wb_arb
// Description : Round-robin writeback arbiter serialising pipe results to ROB.
// Revision    : 1.0 - initial release
// ============================================================================
module rob_wb_arb
   import rob_defs::*;
#(
   parameter int NUM_REQ = RB_NUM_WB_PORTS,
   parameter int DEPTH   = RB_WB_FIFO_DEPTH
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_REQ-1:0] req_valid,
   input  t_rob_result        req_result [NUM_REQ],
   output logic [NUM_REQ-1:0] req_ready,
   input  logic               br_mispred_rb1,
   output logic               ro_valid_rb0,
   output t_rob_result        ro_result_rb0
);

   localparam int                 c_cnt_w = $clog2(DEPTH + 1);
   localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(DEPTH);

   logic [c_cnt_w-1:0] w_count [NUM_REQ];
   t_rob_result        w_head  [NUM_REQ];
   t_rob_result        w_cand_data [NUM_REQ];
   logic [NUM_REQ-1:0] w_empty;
   logic [NUM_REQ-1:0] w_cand;
   logic [NUM_REQ-1:0] w_push;
   logic [NUM_REQ-1:0] w_pop;
   logic               w_gnt_valid;
   t_wb_req_idx        w_winner;

   t_wb_req_idx        r_rr_ptr;
   logic               r_ro_valid;
   t_rob_result        r_ro_result;

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
      logic w_is_winner;

      assign w_is_winner    = w_gnt_valid && (w_winner == t_wb_req_idx'(i));
      assign w_empty[i]     = (w_count[i] == '0);
      assign req_ready[i]   = (w_count[i] < c_depth);
      // Empty FIFO lets the incoming result compete directly (bypass).
      assign w_cand[i]      = !w_empty[i] || req_valid[i];
      assign w_cand_data[i] = w_empty[i] ? req_result[i] : w_head[i];
      assign w_push[i]      = req_valid[i] && !(w_is_winner && w_empty[i]);
      assign w_pop[i]       = w_is_winner && !w_empty[i];

      wb_skid_fifo #(
         .DEPTH (DEPTH),
         .T     (t_rob_result)
      ) u_fifo (
         .clk       (clk),
         .reset     (reset),
         .flush     (br_mispred_rb1),
         .push      (w_push[i]),
         .push_data (req_result[i]),
         .pop       (w_pop[i]),
         .head      (w_head[i]),
         .count     (w_count[i])
      );
   end

   always_comb begin
      w_gnt_valid = 1'b0;
      w_winner    = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!w_gnt_valid && w_cand[wb_idx_wrap(int'(r_rr_ptr) + k, NUM_REQ)]) begin
            w_gnt_valid = 1'b1;
            w_winner    = wb_idx_wrap(int'(r_rr_ptr) + k, NUM_REQ);
         end
      end
   end

   // Mispredict discards the grant and holds the round-robin pointer.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_rr_ptr    <= '0;
         r_ro_valid  <= 1'b0;
         r_ro_result <= '0;
      end else if (br_mispred_rb1) begin
         r_ro_valid  <= 1'b0;
      end else begin
         r_ro_valid <= w_gnt_valid;
         if (w_gnt_valid) begin
            r_ro_result <= w_cand_data[w_winner];
            r_rr_ptr    <= wb_idx_wrap(int'(w_winner) + 1, NUM_REQ);
         end
      end
   end

   assign ro_valid_rb0  = r_ro_valid;
   assign ro_result_rb0 = r_ro_result;

`ifdef ASSERT
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < NUM_REQ; i++)
            assert (!(req_valid[i] && !req_ready[i]));
         if (r_ro_valid)
            assert (r_ro_result.robid < RB_ROBID_W'(RB_NUM_ENTRIES));
         if (w_gnt_valid)
            assert (w_cand[w_winner]);
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_rob_wb_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_rob_wb_arb
// Description : Directed self-checking bench for the writeback arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rob_wb_arb;
   import rob_defs::*;

   localparam int c_n = 3;

   logic           clk = 1'b0;
   logic           reset;
   logic [c_n-1:0] req_valid;
   t_rob_result    req_result [c_n];
   logic [c_n-1:0] req_ready;
   logic           br_mispred_rb1;
   logic           ro_valid_rb0;
   t_rob_result    ro_result_rb0;

   int n_checks = 0;
   int n_errors = 0;
   int exp_seq [c_n];
   int acc     [c_n];
   int acc_total;
   int got_total;
   int last_pipe;
   bit saw_block;

   rob_wb_arb #(
      .NUM_REQ (c_n),
      .DEPTH   (2)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .req_valid      (req_valid),
      .req_result     (req_result),
      .req_ready      (req_ready),
      .br_mispred_rb1 (br_mispred_rb1),
      .ro_valid_rb0   (ro_valid_rb0),
      .ro_result_rb0  (ro_result_rb0)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      req_valid      = '0;
      br_mispred_rb1 = 1'b0;
      for (int i = 0; i < c_n; i++) req_result[i] = '0;
   endtask

   task automatic offer(input int i, input int robid);
      req_valid[i]        = 1'b1;
      req_result[i].robid = RB_ROBID_W'(robid);
      req_result[i].data  = 32'(robid) ^ 32'hA5A5_0000;
   endtask

   task automatic sb_clear();
      for (int i = 0; i < c_n; i++) begin
         exp_seq[i] = 0;
         acc[i]     = 0;
      end
      acc_total = 0;
      got_total = 0;
      last_pipe = -1;
   endtask

   // Offer tagged results on enabled pipes whenever they report ready.
   task automatic drive_en(input logic [c_n-1:0] en);
      for (int i = 0; i < c_n; i++) begin
         if (en[i] && req_ready[i]) begin
            req_valid[i]        = 1'b1;
            req_result[i].robid = RB_ROBID_W'((acc[i] % 16) + 16 * i);
            req_result[i].data  = {16'(i), 16'(acc[i])};
            acc[i]++;
            acc_total++;
         end else begin
            req_valid[i] = 1'b0;
         end
      end
   endtask

   task automatic sb_check(input bit fair);
      int p;
      if (ro_valid_rb0) begin
         p = int'(ro_result_rb0.data[31:16]);
         chk("sb_pipe_range", 64'(p < c_n), 64'd1);
         if (p < c_n) begin
            chk("sb_seq", 64'(ro_result_rb0.data[15:0]), 64'(exp_seq[p]));
            chk("sb_robid", 64'(ro_result_rb0.robid), 64'((exp_seq[p] % 16) + 16 * p));
            exp_seq[p]++;
         end
         if (fair) chk("fair_alt", 64'(p != last_pipe), 64'd1);
         last_pipe = p;
         got_total++;
      end
   endtask

   task automatic drain();
      idle();
      for (int k = 0; k < 12; k++) begin
         step();
         sb_check(1'b0);
      end
      chk("drain_total", 64'(got_total), 64'(acc_total));
      chk("drain_ready", 64'(req_ready), 64'b111);
   endtask

   initial begin
      reset = 1'b1;
      idle();
      step();
      step();
      chk("rst_valid", 64'(ro_valid_rb0), 64'd0);
      chk("rst_result", 64'(ro_result_rb0), 64'd0);
      chk("rst_ready", 64'(req_ready), 64'b111);
      chk("rst_rr_ptr", 64'(dut.r_rr_ptr), 64'd0);
      reset = 1'b0;
      step();

      // Three simultaneous requests with rr_ptr at 0
      offer(0, 1); offer(1, 2); offer(2, 3);
      step();
      idle();
      chk("sim_v1", 64'(ro_valid_rb0), 64'd1);
      chk("sim_id1", 64'(ro_result_rb0.robid), 64'd1);
      step();
      chk("sim_v2", 64'(ro_valid_rb0), 64'd1);
      chk("sim_id2", 64'(ro_result_rb0.robid), 64'd2);
      chk("sim_d2", 64'(ro_result_rb0.data), 64'(32'd2 ^ 32'hA5A5_0000));
      step();
      chk("sim_v3", 64'(ro_valid_rb0), 64'd1);
      chk("sim_id3", 64'(ro_result_rb0.robid), 64'd3);
      chk("sim_ready", 64'(req_ready), 64'b111);
      step();
      chk("sim_idle", 64'(ro_valid_rb0), 64'd0);

      // Single request on pipe 1
      offer(1, 5);
      step();
      idle();
      chk("single_v", 64'(ro_valid_rb0), 64'd1);
      chk("single_id", 64'(ro_result_rb0.robid), 64'd5);
      chk("single_rr", 64'(dut.r_rr_ptr), 64'd2);
      step();
      chk("single_once", 64'(ro_valid_rb0), 64'd0);

      // Fairness between pipes 0 and 2
      sb_clear();
      for (int c = 0; c < 20; c++) begin
         drive_en(3'b101);
         step();
         chk("fair_valid", 64'(ro_valid_rb0), 64'd1);
         sb_check(1'b1);
      end
      drain();

      // Backpressure with every pipe offering whenever ready
      sb_clear();
      saw_block = 1'b0;
      for (int c = 0; c < 15; c++) begin
         if (req_ready != 3'b111) saw_block = 1'b1;
         drive_en(3'b111);
         step();
         chk("bp_throughput", 64'(ro_valid_rb0), 64'd1);
         sb_check(1'b0);
      end
      chk("bp_ready_dropped", 64'(saw_block), 64'd1);
      drain();

      // Flush with four buffered results plus a same-cycle push
      idle();
      offer(0, 10); offer(1, 11); offer(2, 12);
      step();
      idle();
      offer(0, 13); offer(1, 14); offer(2, 15);
      step();
      idle();
      br_mispred_rb1 = 1'b1;
      offer(0, 20);
      step();
      idle();
      chk("flush_valid", 64'(ro_valid_rb0), 64'd0);
      chk("flush_ready", 64'(req_ready), 64'b111);
      offer(1, 30);
      step();
      idle();
      chk("flush_new_v", 64'(ro_valid_rb0), 64'd1);
      chk("flush_new_id", 64'(ro_result_rb0.robid), 64'd30);
      for (int k = 0; k < 5; k++) begin
         step();
         chk("flush_no_leak", 64'(ro_valid_rb0), 64'd0);
      end

      // Reset while FIFOs hold data
      offer(0, 1); offer(1, 2); offer(2, 3);
      step();
      step();
      idle();
      reset = 1'b1;
      step();
      chk("mrst_valid", 64'(ro_valid_rb0), 64'd0);
      chk("mrst_result", 64'(ro_result_rb0), 64'd0);
      chk("mrst_ready", 64'(req_ready), 64'b111);
      chk("mrst_rr_ptr", 64'(dut.r_rr_ptr), 64'd0);
      reset = 1'b0;
      offer(1, 7);
      step();
      idle();
      chk("mrst_req_v", 64'(ro_valid_rb0), 64'd1);
      chk("mrst_req_id", 64'(ro_result_rb0.robid), 64'd7);
      step();
      chk("mrst_req_once", 64'(ro_valid_rb0), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
